// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and the 640x480@60 reference constants.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned pulse;
    int unsigned bp;
    logic        pol;
  } vga_axis_t;

  localparam vga_axis_t VGA_640X480_H = '{active: 640, fp: 16, pulse: 96, bp: 48, pol: 1'b0};
  localparam vga_axis_t VGA_640X480_V = '{active: 480, fp: 10, pulse: 2,  bp: 33, pol: 1'b0};

  function automatic int unsigned axis_total(vga_axis_t a);
    return a.active + a.fp + a.pulse + a.bp;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter with wrap, registered sync decode,
// and next-position decodes so the parent can register aligned outputs.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter vga_axis_t   CFG = VGA_640X480_H,
  parameter int unsigned CW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          last,
  output logic          active_nxt
);

  localparam int unsigned TOTAL = axis_total(CFG);
  // One bit wider than the counter so a sync end of exactly 2**CW does not wrap.
  localparam logic [CW:0] LAST_W = (CW+1)'(TOTAL - 1);
  localparam logic [CW:0] ACT_W  = (CW+1)'(CFG.active);
  localparam logic [CW:0] BEG_W  = (CW+1)'(CFG.active + CFG.fp);
  localparam logic [CW:0] END_W  = (CW+1)'(CFG.active + CFG.fp + CFG.pulse);

  logic [CW-1:0] count_nxt;
  logic [CW:0]   nxt_w;

  assign last       = ({1'b0, count} == LAST_W);
  assign nxt_w      = {1'b0, count_nxt};
  assign active_nxt = (nxt_w < ACT_W);

  // Next position: reset parks on the final position so the first advance wraps to 0.
  always_comb begin
    count_nxt = count;
    if (rst) begin
      count_nxt = LAST_W[CW-1:0];
    end else if (adv) begin
      count_nxt = last ? '0 : count + CW'(1);
    end
  end

  // Counter and sync register, sync decoded from the next position for zero skew.
  always_ff @(posedge clk) begin
    count <= count_nxt;
    if (rst) begin
      sync <= ~CFG.pol;
    end else begin
      sync <= (nxt_w >= BEG_W && nxt_w < END_W) ? CFG.pol : ~CFG.pol;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y position, syncs, video enable and
// line/frame strobes, all registered and mutually aligned.
// Optional macro VGA_TIMING_CE_EN adds a pix_ce pixel clock enable input;
// without it the raster advances every clk cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
  parameter int unsigned H_FP     = VGA_640X480_H.fp,
  parameter int unsigned H_PULSE  = VGA_640X480_H.pulse,
  parameter int unsigned H_BP     = VGA_640X480_H.bp,
  parameter bit          H_POL    = VGA_640X480_H.pol,
  parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
  parameter int unsigned V_FP     = VGA_640X480_V.fp,
  parameter int unsigned V_PULSE  = VGA_640X480_V.pulse,
  parameter int unsigned V_BP     = VGA_640X480_V.bp,
  parameter bit          V_POL    = VGA_640X480_V.pol,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
`ifdef VGA_TIMING_CE_EN
  input  logic          pix_ce,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam vga_axis_t H_CFG = '{active: H_ACTIVE, fp: H_FP, pulse: H_PULSE, bp: H_BP, pol: H_POL};
  localparam vga_axis_t V_CFG = '{active: V_ACTIVE, fp: V_FP, pulse: V_PULSE, bp: V_BP, pol: V_POL};
  localparam int unsigned H_TOTAL = axis_total(H_CFG);
  localparam int unsigned V_TOTAL = axis_total(V_CFG);
  localparam bit CFG_OK = (longint'(H_TOTAL) <= (longint'(1) << CW)) &&
                          (longint'(V_TOTAL) <= (longint'(1) << CW)) &&
                          (H_PULSE != 0) && (V_PULSE != 0);

  logic ce;
  logic h_last, v_last;
  logic h_act_nxt, v_act_nxt;
  logic v_adv;

`ifdef VGA_TIMING_CE_EN
  assign ce = pix_ce;
`else
  assign ce = 1'b1;
`endif

  // The line counter steps only when the pixel counter wraps.
  assign v_adv = ce & h_last;

  vga_axis_timer #(.CFG(H_CFG), .CW(CW)) u_h (
    .clk        (clk),
    .rst        (rst),
    .adv        (ce),
    .count      (x),
    .sync       (hsync),
    .last       (h_last),
    .active_nxt (h_act_nxt)
  );

  vga_axis_timer #(.CFG(V_CFG), .CW(CW)) u_v (
    .clk        (clk),
    .rst        (rst),
    .adv        (v_adv),
    .count      (y),
    .sync       (vsync),
    .last       (v_last),
    .active_nxt (v_act_nxt)
  );

  // Video enable and strobes, decoded from the positions the counters move to this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= h_act_nxt & v_act_nxt;
      line_start  <= ce & h_last;
      frame_start <= ce & h_last & v_last;
    end
  end

  // Timing totals must fit the counters and sync pulses must be non-empty.
  a_cfg_ok : assert property (@(posedge clk) CFG_OK)
    else $error("vga_timing_gen: timing total exceeds 2**CW or a sync pulse width is zero");

endmodule
